// File: rtl/perf_mon_pkg.sv
// Shared constants and helpers for the processor performance/liveness monitor.
// Default encodings match the multi_cycle_processor FSM.
package perf_mon_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } proc_state_e;

    localparam int DEFAULT_STATE_W     = 3;
    localparam int DEFAULT_NUM_STATES  = 5;
    localparam int DEFAULT_FETCH_STATE = int'(ST_FETCH);

    // Increment that sticks at the all-ones value of a w-bit field.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] top;
        top = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v >= top) ? top : v + 64'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter
    import perf_mon_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] q,
    output logic             sat
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= CNT_W'(sat_inc(64'(q), CNT_W));
        end
    end

    assign sat = &q;

endmodule

// File: rtl/perf_watchdog_monitor.sv
// Cycle/instruction/state-residency monitor with a no-progress watchdog and
// an atomic snapshot port, observing the processor FSM state and PC.
module perf_watchdog_monitor
    import perf_mon_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int NUM_STATES  = DEFAULT_NUM_STATES,
    parameter int STATE_W     = DEFAULT_STATE_W,
    parameter int FETCH_STATE = DEFAULT_FETCH_STATE,
    parameter int PC_W        = 32,
    parameter int WDT_W       = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               clear,
    input  logic [STATE_W-1:0] state,
    input  logic [PC_W-1:0]    pc,
    input  logic [WDT_W-1:0]   wdt_limit,
    input  logic [STATE_W-1:0] sel_state,
    input  logic               snap_req,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instr_count,
    output logic [CNT_W-1:0]   state_cycles,
    output logic               snap_valid,
    output logic [CNT_W-1:0]   snap_cycles,
    output logic [CNT_W-1:0]   snap_instrs,
    output logic               wdt_expired,
    output logic [PC_W-1:0]    wdt_pc,
    output logic               illegal_state,
    output logic               overflow
);

    logic [STATE_W-1:0]  prev_state;
    logic [PC_W-1:0]     prev_pc;
    logic [WDT_W-1:0]    idle_cnt;
    logic [WDT_W-1:0]    idle_nxt;
    logic                active;
    logic                legal;
    logic                fetch_entry;
    logic [CNT_W-1:0]    st_cnt [NUM_STATES];
    logic [NUM_STATES+1:0] sat_vec;

    assign active      = enable && !wdt_expired && !clear;
    assign legal       = int'(state) < NUM_STATES;
    assign fetch_entry = (state == STATE_W'(FETCH_STATE)) &&
                         (prev_state != STATE_W'(FETCH_STATE));
    assign idle_nxt    = WDT_W'(sat_inc(64'(idle_cnt), WDT_W));

    sat_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (active),
        .clr     (clear),
        .q       (cycle_count),
        .sat     (sat_vec[NUM_STATES])
    );

    sat_counter #(.CNT_W(CNT_W)) u_instr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (active && fetch_entry),
        .clr     (clear),
        .q       (instr_count),
        .sat     (sat_vec[NUM_STATES+1])
    );

    for (genvar i = 0; i < NUM_STATES; i++) begin : g_state
        sat_counter #(.CNT_W(CNT_W)) u_state (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (active && legal && (state == STATE_W'(i))),
            .clr     (clear),
            .q       (st_cnt[i]),
            .sat     (sat_vec[i])
        );
    end

    // Saturated counters stay at all-ones until clear, so the OR is already sticky.
    assign overflow = |sat_vec;

    always_comb begin
        state_cycles = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (sel_state == STATE_W'(i)) begin
                state_cycles = st_cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_state <= STATE_W'(FETCH_STATE);
            prev_pc    <= '0;
        end else begin
            prev_state <= state;
            prev_pc    <= pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt    <= '0;
            wdt_expired <= 1'b0;
            wdt_pc      <= '0;
        end else if (clear) begin
            idle_cnt    <= '0;
            wdt_expired <= 1'b0;
            wdt_pc      <= '0;
        end else if (active) begin
            if (wdt_limit == '0 || pc != prev_pc) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_nxt;
                if (idle_nxt == wdt_limit) begin
                    wdt_expired <= 1'b1;
                    wdt_pc      <= pc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_state <= 1'b0;
        end else if (clear) begin
            illegal_state <= 1'b0;
        end else if (active && !legal) begin
            illegal_state <= 1'b1;
        end
    end

    // Snapshot captures the pre-increment live values, independent of the freeze.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_valid  <= 1'b0;
            snap_cycles <= '0;
            snap_instrs <= '0;
        end else if (clear) begin
            snap_valid  <= 1'b0;
            snap_cycles <= '0;
            snap_instrs <= '0;
        end else begin
            snap_valid <= snap_req;
            if (snap_req) begin
                snap_cycles <= cycle_count;
                snap_instrs <= instr_count;
            end
        end
    end

endmodule

// File: tb/tb_perf_watchdog_monitor.sv
// Scoreboard bench for perf_watchdog_monitor: a default build and a CNT_W=4 build
// share the same stimulus; a behavioural model queues expected outputs per edge.
module tb_perf_watchdog_monitor;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        clear;
    logic [2:0]  state;
    logic [31:0] pc;
    logic [15:0] wdt_limit;
    logic [2:0]  sel_state;
    logic        snap_req;

    logic [31:0] cycle_count, instr_count, state_cycles, snap_cycles, snap_instrs, wdt_pc;
    logic        snap_valid, wdt_expired, illegal_state, overflow;

    logic [3:0]  c4_cycle, c4_instr, c4_state, c4_snc, c4_sni;
    logic [31:0] c4_wpc;
    logic        c4_snv, c4_exp, c4_ill, c4_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    perf_watchdog_monitor dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .state(state),
        .pc(pc), .wdt_limit(wdt_limit), .sel_state(sel_state), .snap_req(snap_req),
        .cycle_count(cycle_count), .instr_count(instr_count), .state_cycles(state_cycles),
        .snap_valid(snap_valid), .snap_cycles(snap_cycles), .snap_instrs(snap_instrs),
        .wdt_expired(wdt_expired), .wdt_pc(wdt_pc), .illegal_state(illegal_state),
        .overflow(overflow)
    );

    perf_watchdog_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .state(state),
        .pc(pc), .wdt_limit(wdt_limit), .sel_state(sel_state), .snap_req(snap_req),
        .cycle_count(c4_cycle), .instr_count(c4_instr), .state_cycles(c4_state),
        .snap_valid(c4_snv), .snap_cycles(c4_snc), .snap_instrs(c4_sni),
        .wdt_expired(c4_exp), .wdt_pc(c4_wpc), .illegal_state(c4_ill),
        .overflow(c4_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] cyc, ins, stc, snc, sni, wpc;
        logic        snv, expd, ill;
        logic [3:0]  cyc4, ins4, stc4, snc4, sni4;
        logic        ovf4;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [31:0] m_cyc, m_ins, m_snc, m_sni, m_wpc, m_prev_pc;
    logic [31:0] m_st [8];
    logic [15:0] m_idle;
    logic [2:0]  m_prev_state;
    logic        m_exp, m_ill, m_snv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] sat4(input logic [31:0] v);
        return (v >= 32'd15) ? 4'hF : v[3:0];
    endfunction

    task automatic model_reset();
        m_cyc = '0; m_ins = '0; m_snc = '0; m_sni = '0; m_wpc = '0; m_prev_pc = '0;
        for (int k = 0; k < 8; k++) m_st[k] = '0;
        m_idle = '0; m_prev_state = 3'd0; m_exp = 1'b0; m_ill = 1'b0; m_snv = 1'b0;
    endtask

    task automatic model_step();
        logic act;
        act = enable && !m_exp && !clear;
        if (clear) begin
            m_cyc = '0; m_ins = '0; m_snc = '0; m_sni = '0; m_wpc = '0;
            for (int k = 0; k < 8; k++) m_st[k] = '0;
            m_idle = '0; m_exp = 1'b0; m_ill = 1'b0; m_snv = 1'b0;
        end else begin
            m_snv = snap_req;
            if (snap_req) begin
                m_snc = m_cyc;
                m_sni = m_ins;
            end
            if (act) begin
                m_cyc = m_cyc + 32'd1;
                if (state < 3'd5) m_st[state] = m_st[state] + 32'd1;
                else m_ill = 1'b1;
                if (state == 3'd0 && m_prev_state != 3'd0) m_ins = m_ins + 32'd1;
                if (wdt_limit == 16'd0 || pc != m_prev_pc) begin
                    m_idle = '0;
                end else begin
                    m_idle = m_idle + 16'd1;
                    if (m_idle == wdt_limit) begin
                        m_exp = 1'b1;
                        m_wpc = pc;
                    end
                end
            end
        end
        m_prev_state = state;
        m_prev_pc    = pc;
    endtask

    // Apply current inputs for one edge, queue the expectation, compare after the edge.
    task automatic tick();
        exp_t e;
        logic ovf4;
        model_step();
        ovf4 = (m_cyc >= 32'd15) || (m_ins >= 32'd15);
        for (int k = 0; k < 5; k++) if (m_st[k] >= 32'd15) ovf4 = 1'b1;
        e.cyc = m_cyc; e.ins = m_ins; e.snc = m_snc; e.sni = m_sni; e.wpc = m_wpc;
        e.stc = (sel_state < 3'd5) ? m_st[sel_state] : 32'd0;
        e.snv = m_snv; e.expd = m_exp; e.ill = m_ill;
        e.cyc4 = sat4(m_cyc); e.ins4 = sat4(m_ins); e.stc4 = sat4(e.stc);
        e.snc4 = sat4(m_snc); e.sni4 = sat4(m_sni); e.ovf4 = ovf4;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("cycle_count", cycle_count, e.cyc);
        check("instr_count", instr_count, e.ins);
        check("state_cycles", state_cycles, e.stc);
        check("snap_valid", 32'(snap_valid), 32'(e.snv));
        check("snap_cycles", snap_cycles, e.snc);
        check("snap_instrs", snap_instrs, e.sni);
        check("wdt_expired", 32'(wdt_expired), 32'(e.expd));
        check("wdt_pc", wdt_pc, e.wpc);
        check("illegal_state", 32'(illegal_state), 32'(e.ill));
        check("overflow", 32'(overflow), 32'd0);
        check("c4_cycle", 32'(c4_cycle), 32'(e.cyc4));
        check("c4_instr", 32'(c4_instr), 32'(e.ins4));
        check("c4_state", 32'(c4_state), 32'(e.stc4));
        check("c4_snap_valid", 32'(c4_snv), 32'(e.snv));
        check("c4_snap_cycles", 32'(c4_snc), 32'(e.snc4));
        check("c4_snap_instrs", 32'(c4_sni), 32'(e.sni4));
        check("c4_wdt_expired", 32'(c4_exp), 32'(e.expd));
        check("c4_wdt_pc", c4_wpc, e.wpc);
        check("c4_illegal", 32'(c4_ill), 32'(e.ill));
        check("c4_overflow", 32'(c4_ovf), 32'(e.ovf4));
    endtask

    initial begin
        logic [2:0] seq [9];
        logic [2:0] sels [6];
        seq  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd0};
        sels = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};

        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; state = 3'd0; pc = '0;
        wdt_limit = '0; sel_state = 3'd0; snap_req = 1'b0;
        model_reset();

        // Count a little, then pull reset mid-run at t=37 ns between edges
        #10;
        reset_n = 1'b1; enable = 1'b1;
        state = 3'd1; pc = 32'h4; tick();
        state = 3'd2; pc = 32'h8; tick();
        #7;
        reset_n = 1'b0;
        #1;
        check("rst_cycle", cycle_count, 32'd0);
        check("rst_instr", instr_count, 32'd0);
        check("rst_state_cycles", state_cycles, 32'd0);
        check("rst_snap_valid", 32'(snap_valid), 32'd0);
        check("rst_snap_cycles", snap_cycles, 32'd0);
        check("rst_snap_instrs", snap_instrs, 32'd0);
        check("rst_wdt_expired", 32'(wdt_expired), 32'd0);
        check("rst_wdt_pc", wdt_pc, 32'd0);
        check("rst_illegal", 32'(illegal_state), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_c4_cycle", 32'(c4_cycle), 32'd0);
        model_reset();
        #2;
        reset_n = 1'b1;

        // Canonical state walk
        clear = 1'b1; state = 3'd0; pc = '0; tick();
        clear = 1'b0;
        for (int i = 0; i < 9; i++) begin
            state = seq[i];
            pc = 32'h100 + 32'(4 * i);
            tick();
        end
        check("seq_cycle", cycle_count, 32'd9);
        check("seq_instr", instr_count, 32'd2);
        check("seq_wdt", 32'(wdt_expired), 32'd0);
        enable = 1'b0; sel_state = 3'd0; tick();
        check("seq_state0", state_cycles, 32'd3);
        sel_state = 3'd4; tick();
        check("seq_state4", state_cycles, 32'd1);

        // Snapshot handshake
        enable = 1'b1; sel_state = 3'd0; state = 3'd1; pc = 32'h200; tick();
        check("snap_pre_cycle", cycle_count, 32'd10);
        snap_req = 1'b1; state = 3'd2; pc = 32'h204; tick();
        snap_req = 1'b0;
        check("snap_valid", 32'(snap_valid), 32'd1);
        check("snap_cycles", snap_cycles, 32'd10);
        check("snap_post_cycle", cycle_count, 32'd11);
        snap_req = 1'b1; state = 3'd3; pc = 32'h208; tick();
        check("snap_b2b_1", 32'(snap_valid), 32'd1);
        state = 3'd4; pc = 32'h20c; tick();
        check("snap_b2b_2", 32'(snap_valid), 32'd1);
        snap_req = 1'b0; tick();
        snap_req = 1'b1; clear = 1'b1; tick();
        snap_req = 1'b0; clear = 1'b0;
        check("snap_with_clear", 32'(snap_valid), 32'd0);
        check("clear_cycle", cycle_count, 32'd0);

        // Watchdog: PC stuck at 0x40
        wdt_limit = 16'd4; state = 3'd3; pc = 32'h40;
        repeat (4) tick();
        check("wdt_not_yet", 32'(wdt_expired), 32'd0);
        tick();
        check("wdt_fire", 32'(wdt_expired), 32'd1);
        tick();
        check("wdt_pc", wdt_pc, 32'h40);
        check("wdt_frozen_cycle", cycle_count, 32'd5);
        snap_req = 1'b1; tick();
        snap_req = 1'b0;
        check("wdt_snap_cycles", snap_cycles, 32'd5);
        clear = 1'b1; tick();
        clear = 1'b0; wdt_limit = '0;
        check("wdt_clr_expired", 32'(wdt_expired), 32'd0);
        check("wdt_clr_pc", wdt_pc, 32'd0);
        check("wdt_clr_cycle", cycle_count, 32'd0);

        // Illegal state encoding, then idle cycles
        state = 3'd6; pc = 32'h500; tick();
        pc = 32'h504; tick();
        check("ill_flag", 32'(illegal_state), 32'd1);
        check("ill_cycle", cycle_count, 32'd2);
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sel_state = sels[i]; state = sels[i]; pc = 32'h600 + 32'(i);
            tick();
            check("ill_state_cycles", state_cycles, 32'd0);
        end
        check("idle_cycle", cycle_count, 32'd2);

        // Saturation in the narrow build
        enable = 1'b1; clear = 1'b1; tick();
        clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            state = 3'(i % 5); pc = 32'h300 + 32'(4 * i);
            tick();
        end
        check("sat_c4_cycle", 32'(c4_cycle), 32'd15);
        check("sat_c4_overflow", 32'(c4_ovf), 32'd1);
        check("sat_wide_cycle", cycle_count, 32'd20);

        // Mixed random traffic
        for (int i = 0; i < 120; i++) begin
            enable    = ($urandom_range(0, 3) != 0);
            state     = 3'($urandom_range(0, 7));
            pc        = 32'($urandom_range(0, 2)) * 32'd4;
            snap_req  = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 15) == 0);
            wdt_limit = 16'($urandom_range(0, 4));
            sel_state = 3'($urandom_range(0, 7));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
